// File: rtl/ppu_pkg.sv
// Shared PPU sprite types, field offsets and helpers.
// SPRITE_8X16_EN widens the row index to 4 bits for 8x16 sprites.
package ppu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_Y,
    S_CMP,
    S_RD_TILE,
    S_RD_ATTR,
    S_RD_X,
    S_FETCH_LO,
    S_FETCH_HI,
    S_WRITE,
    S_NEXT,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam int SLOT_X    = 0;
  localparam int SLOT_LO   = 8;
  localparam int SLOT_ATTR = 16;
  localparam int SLOT_HI   = 24;

  localparam int ATTR_PRIO  = 5;
  localparam int ATTR_HFLIP = 6;
  localparam int ATTR_VFLIP = 7;

  localparam int CTRL_SPR_TABLE = 3;
  localparam int CTRL_SPR_SIZE  = 5;

  localparam logic [31:0] SLOT_EMPTY = 32'h0000_00FF;

`ifdef SPRITE_8X16_EN
  localparam int ROW_W = 4;
`else
  localparam int ROW_W = 3;
`endif

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sprite_pattern_addr.sv
// Pattern byte address for one sprite row/plane (combinational).
// Ports: tile, diff (row offset), vflip, table_sel, tall
// (SPRITE_8X16_EN only), plane -> addr.
module sprite_pattern_addr
  import ppu_pkg::*;
(
  input  logic [7:0]       tile,
  input  logic [ROW_W-1:0] diff,
  input  logic             vflip,
  input  logic             table_sel,
`ifdef SPRITE_8X16_EN
  input  logic             tall,
`endif
  input  logic             plane,
  output logic [12:0]      addr
);

  logic [ROW_W-1:0] row;

`ifdef SPRITE_8X16_EN
  // (H-1)-diff is a plain inversion of the row bits
  always_comb begin
    row = diff;
    if (vflip) row = tall ? ~diff : {1'b0, ~diff[2:0]};
    if (tall)
      addr = {tile[0], tile[7:1], row[3], plane, row[2:0]};
    else
      addr = {table_sel, tile, plane, row[2:0]};
  end
`else
  always_comb begin
    row  = vflip ? ~diff : diff;
    addr = {table_sel, tile, plane, row};
  end
`endif

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluation, pattern fetch and slot load.
// Ports: start/line/ctrl in; OAM read, CHR handshake, slot write,
// slot_valid/overflow/busy/done out. Macro: SPRITE_8X16_EN.
module sprite_line_scheduler
  import ppu_pkg::*;
#(
  parameter int MAX_SLOTS   = 8,
  parameter int OAM_SPRITES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  line,
  input  logic [7:0]  ctrl,
  output logic [7:0]  oam_addr,
  input  logic [7:0]  oam_data,
  output logic        chr_req,
  output logic [12:0] chr_addr,
  input  logic        chr_ack,
  input  logic [7:0]  chr_data,
  output logic        slot_we,
  output logic [2:0]  slot_idx,
  output logic [31:0] slot_data,
  output logic [7:0]  slot_valid,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] SLOT_END = 4'(MAX_SLOTS);
  localparam logic [5:0] LAST_SPR = 6'(OAM_SPRITES - 1);

  state_t           state, nxt;
  logic [5:0]       n;
  logic [3:0]       slot;
  logic [8:0]       line_q;
  logic             tbl_q;
  logic [ROW_W-1:0] diff_q;
  logic [7:0]       tile_q, attr_q, x_q, lo_q, hi_q;
  logic [8:0]       diff;
  logic [4:0]       h;
  logic             in_range;
  logic [12:0]      pat_addr;
  logic [7:0]       chr_byte;

`ifdef SPRITE_8X16_EN
  logic tall_q;
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[7:6], ctrl[4], ctrl[2:0]};
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[7:4], ctrl[2:0]};
`endif

  always_comb begin
    h = 5'd8;
`ifdef SPRITE_8X16_EN
    if (tall_q) h = 5'd16;
`endif
    // a sprite below the line wraps to a large diff and misses
    diff     = line_q - {1'b0, oam_data};
    in_range = diff < {4'd0, h};
    chr_byte = attr_q[ATTR_HFLIP] ? rev8(chr_data) : chr_data;
  end

  sprite_pattern_addr u_addr (
    .tile      (tile_q),
    .diff      (diff_q),
    .vflip     (attr_q[ATTR_VFLIP]),
    .table_sel (tbl_q),
`ifdef SPRITE_8X16_EN
    .tall      (tall_q),
`endif
    .plane     (state == S_FETCH_HI),
    .addr      (pat_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:     if (start) nxt = S_RD_Y;
      S_RD_Y:     nxt = S_CMP;
      S_CMP: begin
        if (!in_range)           nxt = S_NEXT;
        else if (slot == SLOT_END) nxt = S_CLEAR;
        else                     nxt = S_RD_TILE;
      end
      S_RD_TILE:  nxt = S_RD_ATTR;
      S_RD_ATTR:  nxt = S_RD_X;
      S_RD_X:     nxt = S_FETCH_LO;
      S_FETCH_LO: if (chr_ack) nxt = S_FETCH_HI;
      S_FETCH_HI: if (chr_ack) nxt = S_WRITE;
      S_WRITE:    nxt = S_NEXT;
      S_NEXT:     nxt = (n == LAST_SPR) ? S_CLEAR : S_RD_Y;
      S_CLEAR:    if (slot >= SLOT_END - 4'd1) nxt = S_DONE;
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // OAM address runs one byte ahead of the state consuming it
  always_comb begin
    oam_addr  = '0;
    chr_req   = 1'b0;
    chr_addr  = '0;
    slot_we   = 1'b0;
    slot_idx  = '0;
    slot_data = '0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    unique case (state)
      S_RD_Y:    oam_addr = {n, 2'd0};
      S_CMP:     oam_addr = {n, 2'd1};
      S_RD_TILE: oam_addr = {n, 2'd2};
      S_RD_ATTR: oam_addr = {n, 2'd3};
      S_FETCH_LO, S_FETCH_HI: begin
        chr_req  = 1'b1;
        chr_addr = pat_addr;
      end
      S_WRITE: begin
        slot_we                = 1'b1;
        slot_idx               = slot[2:0];
        slot_data[SLOT_X+:8]    = x_q;
        slot_data[SLOT_LO+:8]   = lo_q;
        slot_data[SLOT_ATTR+:8] = attr_q;
        slot_data[SLOT_HI+:8]   = hi_q;
      end
      S_CLEAR: begin
        if (slot < SLOT_END) begin
          slot_we   = 1'b1;
          slot_idx  = slot[2:0];
          slot_data = SLOT_EMPTY;
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n          <= '0;
      slot       <= '0;
      line_q     <= '0;
      tbl_q      <= 1'b0;
      diff_q     <= '0;
      tile_q     <= '0;
      attr_q     <= '0;
      x_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      slot_valid <= '0;
      overflow   <= 1'b0;
`ifdef SPRITE_8X16_EN
      tall_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n          <= '0;
            slot       <= '0;
            slot_valid <= '0;
            overflow   <= 1'b0;
            line_q     <= line;
            tbl_q      <= ctrl[CTRL_SPR_TABLE];
`ifdef SPRITE_8X16_EN
            tall_q     <= ctrl[CTRL_SPR_SIZE];
`endif
          end
        end
        S_CMP: begin
          diff_q <= diff[ROW_W-1:0];
          if (in_range && slot == SLOT_END) overflow <= 1'b1;
        end
        S_RD_TILE:  tile_q <= oam_data;
        S_RD_ATTR:  attr_q <= oam_data;
        S_RD_X:     x_q    <= oam_data;
        S_FETCH_LO: if (chr_ack) lo_q <= chr_byte;
        S_FETCH_HI: if (chr_ack) hi_q <= chr_byte;
        S_WRITE: begin
          slot_valid[slot[2:0]] <= 1'b1;
          slot <= slot + 4'd1;
        end
        S_NEXT:  if (n != LAST_SPR) n <= n + 6'd1;
        S_CLEAR: if (slot < SLOT_END) slot <= slot + 4'd1;
        default: ;
      endcase
    end
  end

endmodule
